// File: rtl/bcd_serial_adder_pkg.sv
// bcd_pkg: shared BCD constants, FSM encoding and digit validity helper
package bcd_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic bcd_valid(input logic [BCD_W-1:0] digit);
    return digit <= BCD_NINE;
  endfunction
endpackage

// File: rtl/bcd_serial_adder_if.sv
// bcd_serial_adder_if: start/done operand and result bundle for the serial BCD adder
interface bcd_serial_adder_if #(parameter int DIGITS = 4);
  localparam int W = bcd_pkg::BCD_W * DIGITS;
  logic start, sub, busy, done, carry_out, invalid;
  logic [W-1:0] a, b, sum;
  modport master(output start, sub, a, b, input busy, done, sum, carry_out, invalid);
  modport slave(input start, sub, a, b, output busy, done, sum, carry_out, invalid);
endinterface

// File: rtl/bcd_serial_adder_digit_add.sv
// bcd_digit_add: one BCD digit add with decimal carry and +6 correction
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             ci,
  output logic [BCD_W-1:0] d,
  output logic             co
);
  logic [BCD_W:0] s;
  // binary sum, then fold values above nine back into a decimal digit
  always_comb begin
    s = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, ci};
    co = s > (BCD_W+1)'(BCD_NINE);
    d = co ? s[BCD_W-1:0] + BCD_W'(6) : s[BCD_W-1:0];
  end
endmodule

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial packed BCD adder/subtractor (subtract built when BCD_SUB_EN is defined)
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input logic clk,
  input logic reset,
  bcd_serial_adder_if.slave bus
);
  localparam int W = BCD_W * DIGITS;
  localparam int IW = $clog2(DIGITS + 1);
  state_t state, state_nx;
  logic [W-1:0] ar, br, res, res_nx;
  logic [IW-1:0] idx;
  logic [BCD_W-1:0] bd, dig;
  logic c, co, last, go, sub_in;
  assign go = (state == IDLE) && bus.start;
  assign last = idx == IW'(DIGITS - 1);
`ifdef BCD_SUB_EN
  logic sr;
  assign sub_in = bus.sub;
  assign bd = sr ? BCD_NINE - br[BCD_W-1:0] : br[BCD_W-1:0];
  // operation mode latched with the accepted start
  always_ff @(posedge clk)
    if (reset) sr <= 1'b0;
    else if (go) sr <= bus.sub;
`else
  logic unused_sub;
  assign unused_sub = bus.sub;
  assign sub_in = 1'b0;
  assign bd = br[BCD_W-1:0];
`endif
  bcd_digit_add u_add (.a(ar[BCD_W-1:0]), .b(bd), .ci(c), .d(dig), .co(co));
  assign res_nx = (res >> BCD_W) | (W'(dig) << (W - BCD_W));
  // state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // next state: one RUN cycle per digit, then a single DONE cycle
  always_comb
    state_nx = state == IDLE ? (bus.start ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) : IDLE;
  // handshake outputs decoded from state
  always_comb begin
    bus.busy = state != IDLE;
    bus.done = state == DONE;
  end
  // operand shifters, carry chain, result assembly and sticky invalid flag
  always_ff @(posedge clk)
    if (reset) begin
      ar <= '0;
      br <= '0;
      res <= '0;
      idx <= '0;
      c <= 1'b0;
      bus.sum <= '0;
      bus.carry_out <= 1'b0;
      bus.invalid <= 1'b0;
    end else if (go) begin
      ar <= bus.a;
      br <= bus.b;
      idx <= '0;
      c <= sub_in;
      bus.invalid <= 1'b0;
    end else if (state == RUN) begin
      ar <= ar >> BCD_W;
      br <= br >> BCD_W;
      idx <= idx + 1'b1;
      c <= co;
      res <= res_nx;
      bus.invalid <= bus.invalid | ~bcd_valid(ar[BCD_W-1:0]) | ~bcd_valid(br[BCD_W-1:0]);
      if (last) begin
        bus.sum <= res_nx;
        bus.carry_out <= co;
      end
    end
endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder: randomized check of bcd_serial_adder against a decimal arithmetic model
module tb_bcd_serial_adder;
  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] last_sum = '0;
  bit last_ok = 1'b1;
  bcd_serial_adder_if #(.DIGITS(DIGITS)) bus();
  bcd_serial_adder #(.DIGITS(DIGITS)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint to_int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i+:4]);
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input longint v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++) if (v[4*i+:4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i+:4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 15) == 0) r[4*$urandom_range(0, DIGITS-1)+:4] = 4'($urandom_range(10, 15));
    return r;
  endfunction

  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                       output logic [W-1:0] es, output logic ec, output logic ei);
    longint m = 1;
    longint x = to_int(av);
    longint y = to_int(bv);
    for (int i = 0; i < DIGITS; i++) m = m * 10;
`ifndef BCD_SUB_EN
    sv = 1'b0;
`endif
    ei = has_bad(av) | has_bad(bv);
    ec = sv ? (x >= y) : (x + y >= m);
    es = sv ? to_bcd((x - y + m) % m) : to_bcd((x + y) % m);
  endtask

  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv, input bit glitch);
    logic [W-1:0] es;
    logic ec, ei;
    int dn = 0;
    model(av, bv, sv, es, ec, ei);
    bus.start = 1'b1;
    bus.a = av;
    bus.b = bv;
    bus.sub = sv;
    for (int k = 0; k <= DIGITS + 1; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.start = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        bus.sub = 1'($urandom);
      end
      check("busy", bus.busy, 64'(k <= DIGITS));
      check("done", bus.done, 64'(k == DIGITS));
      if (bus.done) dn++;
      if (k < DIGITS && last_ok) check("held_sum", bus.sum, last_sum);
      if (k == DIGITS) begin
        check("invalid", bus.invalid, ei);
        if (!ei) begin
          check("sum", bus.sum, es);
          check("carry_out", bus.carry_out, ec);
        end
      end
      bus.start = glitch && (k == 1 || k == DIGITS);
    end
    check("done_count", dn, 1);
    last_sum = es;
    last_ok = !ei;
  endtask

  initial begin
    int dn;
    bus.start = 1'b0;
    bus.sub = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_carry", bus.carry_out, 0);
    check("rst_invalid", bus.invalid, 0);
    reset = 1'b0;
    @(negedge clk);
    do_op(16'h1234, 16'h5678, 1'b0, 1'b0);
    do_op(16'h9999, 16'h0001, 1'b0, 1'b0);
    do_op(16'h5000, 16'h1234, 1'b1, 1'b0);
    do_op(16'h1234, 16'h5000, 1'b1, 1'b0);
    do_op(16'h00A0, 16'h0000, 1'b0, 1'b0);
    do_op(16'h0042, 16'h0058, 1'b0, 1'b1);
    do_op(16'h0000, 16'h0000, 1'b1, 1'b0);
    bus.start = 1'b1;
    bus.a = 16'h1111;
    bus.b = 16'h2222;
    bus.sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_sum", bus.sum, 0);
    check("abort_carry", bus.carry_out, 0);
    check("abort_invalid", bus.invalid, 0);
    reset = 1'b0;
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      dn += int'(bus.done);
    end
    check("abort_no_done", dn, 0);
    last_sum = '0;
    last_ok = 1'b1;
    do_op(16'h0815, 16'h4711, 1'b0, 1'b0);
    repeat (60) do_op(rand_bcd(), rand_bcd(), 1'($urandom), $urandom_range(0, 3) == 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bcd_serial_adder.md
# bcd_serial_adder

Multi-digit, digit-serial BCD adder/subtractor. It generalises the single-digit BCD add-and-correct datapath to `DIGITS` packed BCD digits, processing one digit per clock from the least-significant digit upward. It sits behind any block needing decimal arithmetic on packed BCD words, such as counters, display drivers and calculator datapaths. Operands are accepted with a start/done handshake.

## Interface
Parameters:
- `DIGITS`, default 4: number of packed BCD digits per operand; legal range 1–16.

Ports:
- `clk`: input, 1 bit. Sole clock; all logic on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-high reset.
- `start`: input, 1 bit. Request an operation; sampled only in IDLE.
- `sub`: input, 1 bit. 0 = add (a+b); 1 = subtract (a−b). Sampled with `start`.
- `a`: input, 4*DIGITS bits. Augend/minuend, packed BCD, digit 0 in bits [3:0].
- `b`: input, 4*DIGITS bits. Addend/subtrahend, packed BCD.
- `busy`: output, 1 bit. High from the cycle after an accepted `start` until `done`, inclusive.
- `done`: output, 1 bit. One-cycle pulse when the result is valid.
- `sum`: output, 4*DIGITS bits. Result; held until the next accepted `start`.
- `carry_out`: output, 1 bit. Decimal carry out of the top digit. In subtract mode, 1 = no borrow (a≥b).
- `invalid`: output, 1 bit. High with `sum` if any input digit of `a` or `b` exceeded 9.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`=1. On that edge, latch `a`, `b` and `sub`, clear the digit index, and set the carry register to `sub`.
  - RUN processes digit `idx` each cycle and increments `idx`. After digit DIGITS−1 it moves to DONE.
  - DONE asserts `done` for one cycle, then returns to IDLE.
- Per digit:
  - Operand b digit is `sub ? 9−b_i : b_i` (nine's complement).
  - Binary sum s = a_i + b'_i + c, 5 bits.
  - Decimal carry = s>9.
  - Result digit = (carry ? s+6 : s) mod 16.
  - The carry is registered into the next digit.
- Subtract result:
  - When a≥b: a−b with `carry_out`=1.
  - Otherwise: ten's complement, 10^DIGITS − (b−a), with `carry_out`=0. No sign/magnitude conversion.
- `invalid`:
  - The latched operands are checked digit-by-digit during RUN; the flag is sticky for the operation and cleared on the next accepted `start`.
  - Digits above 9 are still processed by the same rule, with no further guarantee on `sum`.
- `start` while `busy` or during DONE is ignored; the operation in flight is unaffected. Input changes after acceptance have no effect.
- `sum` is assembled in a shift register and updates only when entering DONE. Mid-operation `sum` keeps the previous result.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `sum`=0, `carry_out`=0, `invalid`=0, internal carry/index=0.
- `reset` during RUN or DONE returns to IDLE on the same edge. No `done` is produced for the aborted operation and outputs take their reset values.
- Latency: `start` sampled at edge 0; `busy` is high from edge 0 to edge DIGITS+1; `done`, `sum`, `carry_out` and `invalid` are valid in the cycle following edge DIGITS (DIGITS+1 cycles per operation).
- Back-to-back: a new `start` is accepted in the first IDLE cycle after DONE. Throughput is one operation per DIGITS+2 cycles.
- `reset` has priority over `start` when both are asserted together.

## Configuration
- `BCD_SUB_EN` defined: subtract mode is built as described.
- `BCD_SUB_EN` undefined:
  - The complement logic is removed and `sub` is ignored (treated as 0).
  - The carry register initialises to 0.
  - The port list is unchanged.

## Structure
- Shared package `bcd_pkg`:
  - Constant BCD_W=4 and constant BCD_NINE=4'd9.
  - FSM state encoding (IDLE, RUN, DONE).
  - Function `bcd_valid(digit)`.
- Sub-module `bcd_digit_add` is combinational: digit a, digit b', carry in → digit, carry out, with the +6 correction. It is instantiated once and time-multiplexed over the digits. The parent holds the FSM, operand shift registers, carry and index.

## Test plan
- DIGITS=4, add 1234+5678 → `sum`=6912, `carry_out`=0, `done` one cycle at start+5, `busy` high 5 cycles.
- Add 9999+0001 → `sum`=0000, `carry_out`=1; the carry ripples through all digits.
- Sub 5000−1234 → `sum`=3766, `carry_out`=1. Sub 1234−5000 → `sum`=6234, `carry_out`=0.
- Add a=0x00A0 (invalid digit), b=0000 → `invalid`=1 with `done`. The next valid operation → `invalid`=0.
- Start at cycle 0; `reset` at cycle 2 → outputs 0 on the following cycle, no `done` pulse. Start again → correct result.
- Pulse `start` with new operands while `busy` → ignored; the first result is unchanged and exactly one `done` is produced.
